// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: clear-FSM state
// encodings and the address-width helper.
package regfile_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Address width for n entries, never below one bit.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks every register index once, one per cycle,
// then pulses clr_done for a single cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 16,
  localparam int ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            idx   <= '0;
          end
        end
        ST_CLEAR: begin
          if (idx == ADDR_W'(NUM_REGS - 1)) begin
            state <= ST_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign clr_busy = (state == ST_CLEAR);
  assign clr_done = (state == ST_DONE);
  assign clr_we   = clr_busy;
  assign clr_idx  = idx;

endmodule

// File: rtl/regfile_param.sv
// Decode-stage register file: one write port, two combinational read ports,
// optional write bypass, optional hardwired-zero r0 and a bulk-clear engine.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = addr_w(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              user_we;

  regfile_clear_fsm #(.NUM_REGS(NUM_REGS)) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  assign wr_ready = !clr_busy;
  // Dropped r0 writes are masked here so they neither store nor bypass.
  assign user_we  = wr_en && wr_ready && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (user_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = mem[rd_addr1];
    if ((BYPASS != 0) && user_we && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = mem[rd_addr2];
    if ((BYPASS != 0) && user_we && (wr_addr == rd_addr2)) rd_data2 = wr_data;
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) rd_data2 = '0;
  end

endmodule
